// File: rtl/host_message_endpoint.sv
// Decoder-side endpoint of the 8-bit host byte protocol: parses START/MEAS_HDR/data,
// hands one round-set of measurements to the decoder core, times the decode, returns a 3-byte result.
module host_message_endpoint #(
  parameter int          GRID_WIDTH_X = 6,
  parameter int          GRID_WIDTH_Z = 2,
  parameter int          GRID_WIDTH_U = 5,
  parameter logic [7:0]  START_MSG    = 8'h01,
  parameter logic [7:0]  MEAS_HDR     = 8'h02,
  localparam int         BPR          = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) >> 3,
  localparam int         NBYTES       = BPR * GRID_WIDTH_U,
  localparam int         MEAS_W       = 8 * NBYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        input_data,
  input  logic              input_valid,
  output logic              input_ready,
  output logic [7:0]        output_data,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [MEAS_W-1:0] measurements,
  output logic              decode_start,
  input  logic              decode_done,
  input  logic [7:0]        iteration_count,
  output logic              busy,
  output logic              protocol_error
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_HDR, LOAD, DECODE, SEND} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] load_idx_reg;
  logic [1:0]       send_idx_reg;
  logic             first_reg;
  logic [15:0]      count_reg;
  logic [7:0]       iter_reg;
  logic             protocol_error_reg;

  logic in_fire, out_fire, hdr_fire, load_fire, last_byte, done_fire;

  assign in_fire   = input_valid & input_ready;
  assign out_fire  = output_valid & output_ready;
  assign hdr_fire  = (state_reg == WAIT_HDR) && in_fire && (input_data == MEAS_HDR);
  assign load_fire = (state_reg == LOAD) && in_fire;
  assign last_byte = (load_idx_reg == IDX_W'(NBYTES - 1));
  // decode_done in the decode_start cycle is deliberately ignored
  assign done_fire = (state_reg == DECODE) && !first_reg && decode_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (in_fire && input_data == START_MSG) state_next = WAIT_HDR;
      WAIT_HDR: if (hdr_fire) state_next = LOAD;
      LOAD:     if (load_fire && last_byte) state_next = DECODE;
      DECODE:   if (done_fire) state_next = SEND;
      SEND:     if (out_fire && send_idx_reg == 2'd2) state_next = WAIT_HDR;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    input_ready  = (state_reg == IDLE) || (state_reg == WAIT_HDR) || (state_reg == LOAD);
    output_valid = (state_reg == SEND);
    busy         = (state_reg == DECODE) || (state_reg == SEND);
    decode_start = (state_reg == DECODE) && first_reg;
    output_data  = 8'h00;
    if (state_reg == SEND) begin
      case (send_idx_reg)
        2'd0:    output_data = iter_reg;
        2'd1:    output_data = count_reg[15:8];
        default: output_data = count_reg[7:0];
      endcase
    end
  end

  assign protocol_error = protocol_error_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_idx_reg       <= '0;
      send_idx_reg       <= 2'd0;
      first_reg          <= 1'b0;
      count_reg          <= 16'd0;
      iter_reg           <= 8'd0;
      protocol_error_reg <= 1'b0;
    end else begin
      first_reg <= load_fire && last_byte;
      if (hdr_fire)       load_idx_reg <= '0;
      else if (load_fire) load_idx_reg <= load_idx_reg + 1'b1;
      if (state_reg == IDLE && in_fire && input_data != START_MSG)
        protocol_error_reg <= 1'b1;
      if (state_reg == WAIT_HDR && in_fire && input_data != START_MSG && input_data != MEAS_HDR)
        protocol_error_reg <= 1'b1;
      if (state_reg == DECODE) begin
        if (first_reg)
          count_reg <= 16'd0;
        else if (!decode_done && count_reg != 16'hFFFF)
          count_reg <= count_reg + 16'd1;
      end
      if (done_fire) begin
        iter_reg     <= iteration_count;
        send_idx_reg <= 2'd0;
      end else if (out_fire) begin
        send_idx_reg <= (send_idx_reg == 2'd2) ? 2'd0 : send_idx_reg + 2'd1;
      end
    end
  end

  // One register lane per measurement byte, cleared when a new header is accepted
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          lane_reg <= 8'h00;
        else if (hdr_fire)
          lane_reg <= 8'h00;
        else if (load_fire && load_idx_reg == IDX_W'(gi))
          lane_reg <= input_data;
      end
      assign measurements[8*gi +: 8] = lane_reg;
    end
  endgenerate

endmodule
